// File: rtl/ifft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback stage for the inverse FFT (conjugate twiddle rotation).
// Build option: define IFFT_STAGE_SCALE_EN to halve every butterfly output (1/N overall gain).

module ifft_sdf_stage #(
    parameter int bit_width           = 16,
    parameter int bit_width_tw_factor = 16,
    parameter int delay_depth         = 128,
    parameter int addr_w              = (delay_depth > 1) ? $clog2(delay_depth) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic signed [bit_width-1:0]           Re_in,
    input  logic signed [bit_width-1:0]           Im_in,
    output logic        [addr_w-1:0]              tw_addr,
    input  logic signed [bit_width_tw_factor-1:0] cos_data,
    input  logic signed [bit_width_tw_factor-1:0] sin_data,
    output logic                                  out_valid,
    output logic signed [bit_width-1:0]           Re_out,
    output logic signed [bit_width-1:0]           Im_out,
    output logic                                  out_last
);

    localparam int BW    = bit_width;
    localparam int TW    = bit_width_tw_factor;
    localparam int LOG_D = $clog2(delay_depth);
    localparam int CW    = LOG_D + 1;
    localparam int SH    = TW - 2;
    localparam int PW    = BW + TW;

    // Butterfly output stage: optional halving, then wrap to the sample width.
    function automatic logic signed [BW-1:0] f_scale(input logic signed [BW:0] v);
`ifdef IFFT_STAGE_SCALE_EN
        return BW'(v >>> 1);
`else
        return BW'(v);
`endif
    endfunction

    logic [CW-1:0]          r_cnt;
    logic                   r_primed;
    logic                   r_valid;
    logic                   r_last;
    logic signed [BW-1:0]   r_re;
    logic signed [BW-1:0]   r_im;
    logic [2*BW-1:0]        r_dl [delay_depth];

    logic                   w_phase;
    logic                   w_cnt_end;
    logic [2*BW-1:0]        w_dl_out;
    logic [2*BW-1:0]        w_dl_in;
    logic signed [BW-1:0]   w_a_re;
    logic signed [BW-1:0]   w_a_im;
    logic signed [BW:0]     w_sum_re;
    logic signed [BW:0]     w_sum_im;
    logic signed [BW:0]     w_dif_re;
    logic signed [BW:0]     w_dif_im;
    logic signed [BW-1:0]   w_s_sum_re;
    logic signed [BW-1:0]   w_s_sum_im;
    logic signed [BW-1:0]   w_d_re;
    logic signed [BW-1:0]   w_d_im;
    logic signed [PW-1:0]   w_p_rc;
    logic signed [PW-1:0]   w_p_is;
    logic signed [PW-1:0]   w_p_ic;
    logic signed [PW-1:0]   w_p_rs;
    logic signed [PW:0]     w_rf_re;
    logic signed [PW:0]     w_rf_im;
    logic signed [BW-1:0]   w_rot_re;
    logic signed [BW-1:0]   w_rot_im;

    // The counter spans exactly 2D values, so the natural binary wrap gives 2D-1 -> 0.
    assign w_phase   = r_cnt[CW-1];
    assign w_cnt_end = (r_cnt == CW'(delay_depth - 1));

    // Delay line as a circular buffer: the slot read this cycle was written D accepts ago.
    generate
        if (delay_depth == 1) begin : g_depth_one
            assign w_dl_out = r_dl[0];
            assign tw_addr  = '0;
            always_ff @(posedge clk) begin
                if (in_valid) begin
                    r_dl[0] <= w_dl_in;
                end
            end
        end else begin : g_depth_n
            logic [LOG_D-1:0] w_idx;
            assign w_idx    = r_cnt[LOG_D-1:0];
            assign w_dl_out = r_dl[w_idx];
            assign tw_addr  = addr_w'(w_idx);
            always_ff @(posedge clk) begin
                if (in_valid) begin
                    r_dl[w_idx] <= w_dl_in;
                end
            end
        end
    endgenerate

    assign {w_a_re, w_a_im} = w_dl_out;

    assign w_sum_re = (BW+1)'(w_a_re) + (BW+1)'(Re_in);
    assign w_sum_im = (BW+1)'(w_a_im) + (BW+1)'(Im_in);
    assign w_dif_re = (BW+1)'(w_a_re) - (BW+1)'(Re_in);
    assign w_dif_im = (BW+1)'(w_a_im) - (BW+1)'(Im_in);

    assign w_s_sum_re = f_scale(w_sum_re);
    assign w_s_sum_im = f_scale(w_sum_im);
    assign w_d_re     = f_scale(w_dif_re);
    assign w_d_im     = f_scale(w_dif_im);

    // Conjugate twiddle: (re + j im)(cos - j sin).
    assign w_p_rc  = PW'(w_d_re) * PW'(cos_data);
    assign w_p_is  = PW'(w_d_im) * PW'(sin_data);
    assign w_p_ic  = PW'(w_d_im) * PW'(cos_data);
    assign w_p_rs  = PW'(w_d_re) * PW'(sin_data);
    assign w_rf_re = (PW+1)'(w_p_rc) + (PW+1)'(w_p_is);
    assign w_rf_im = (PW+1)'(w_p_ic) - (PW+1)'(w_p_rs);
    assign w_rot_re = BW'(w_rf_re >>> SH);
    assign w_rot_im = BW'(w_rf_im >>> SH);

    assign w_dl_in = w_phase ? {w_rot_re, w_rot_im} : {Re_in, Im_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_re     <= '0;
            r_im     <= '0;
        end else begin
            r_valid <= in_valid & (w_phase | r_primed);
            r_last  <= in_valid & r_primed & ~w_phase & w_cnt_end;
            if (in_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_cnt_end) begin
                    r_primed <= 1'b1;
                end
                if (w_phase) begin
                    r_re <= w_s_sum_re;
                    r_im <= w_s_sum_im;
                end else begin
                    r_re <= w_a_re;
                    r_im <= w_a_im;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign Re_out    = r_re;
    assign Im_out    = r_im;

endmodule

// File: tb/tb_ifft_sdf_stage.sv
// Self-checking bench for ifft_sdf_stage (D=4, 16-bit samples and twiddles).
// Honours IFFT_STAGE_SCALE_EN in its reference model and literal expectations.

module tb_ifft_sdf_stage;

    localparam int D  = 4;
    localparam int AW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] re_in = '0;
    logic signed [15:0] im_in = '0;
    logic [AW-1:0]      tw_addr;
    logic signed [15:0] cos_data;
    logic signed [15:0] sin_data;
    logic               out_valid;
    logic signed [15:0] re_out;
    logic signed [15:0] im_out;
    logic               out_last;

    logic signed [15:0] lut_cos [D];
    logic signed [15:0] lut_sin [D];

    int total = 0;
    int bad   = 0;

    // Reference model state: full history of accepted samples and twiddles used.
    int m_n;
    int m_xr[$];
    int m_xi[$];
    int m_c[$];
    int m_s[$];

    ifft_sdf_stage #(
        .bit_width          (16),
        .bit_width_tw_factor(16),
        .delay_depth        (D),
        .addr_w             (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .Re_in    (re_in),
        .Im_in    (im_in),
        .tw_addr  (tw_addr),
        .cos_data (cos_data),
        .sin_data (sin_data),
        .out_valid(out_valid),
        .Re_out   (re_out),
        .Im_out   (im_out),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        cos_data = lut_cos[tw_addr];
        sin_data = lut_sin[tw_addr];
    end

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int bfly(input int a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
`ifdef IFFT_STAGE_SCALE_EN
        s = s >>> 1;
`endif
        return wrap16(s);
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_xr.delete();
        m_xi.delete();
        m_c.delete();
        m_s.delete();
    endtask

    // Block-level view: sample n sits at position n mod 2D; the upper half pairs with
    // x[n-D] for the sum, the lower half (from the second block on) emits the rotated
    // difference formed one half-block earlier.
    task automatic model_step(input bit v, input int re, input int im, output bit ev,
                              output bit el, output int er, output int ei, output int ea);
        int j, dr, di, c, s;
        ev = 1'b0;
        el = 1'b0;
        er = 0;
        ei = 0;
        ea = m_n % D;
        if (v) begin
            j = m_n % (2 * D);
            m_xr.push_back(re);
            m_xi.push_back(im);
            m_c.push_back(int'(lut_cos[m_n % D]));
            m_s.push_back(int'(lut_sin[m_n % D]));
            if (j >= D) begin
                ev = 1'b1;
                er = bfly(m_xr[m_n-D], re);
                ei = bfly(m_xi[m_n-D], im);
            end else if (m_n >= 2 * D) begin
                ev = 1'b1;
                dr = bfly(m_xr[m_n-2*D], -m_xr[m_n-D]);
                di = bfly(m_xi[m_n-2*D], -m_xi[m_n-D]);
                c  = m_c[m_n-D];
                s  = m_s[m_n-D];
                er = wrap16((longint'(dr) * longint'(c) + longint'(di) * longint'(s)) >>> 14);
                ei = wrap16((longint'(di) * longint'(c) - longint'(dr) * longint'(s)) >>> 14);
                el = (j == D - 1);
            end
            m_n++;
        end
    endtask

    // Drives one cycle and returns both the observed outputs and the model's expectation.
    task automatic step(input bit v, input int re, input int im,
                        output logic ov, output logic ol, output int ore, output int oim,
                        output int oa, output bit ev, output bit el, output int er,
                        output int ei, output int ea);
        in_valid = v;
        re_in    = re[15:0];
        im_in    = im[15:0];
        oa       = int'(tw_addr);
        model_step(v, re, im, ev, el, er, ei, ea);
        @(posedge clk);
        #1;
        ov  = out_valid;
        ol  = out_last;
        ore = int'(re_out);
        oim = int'(im_out);
    endtask

    task automatic set_lut(input int c, input int s);
        for (int i = 0; i < D; i++) begin
            lut_cos[i] = c[15:0];
            lut_sin[i] = s[15:0];
        end
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        set_lut(16384, 0);
        rst_n = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %0b want 0", out_last); end
        total++; if (re_out !== 16'sd0) begin bad++; $display("FAIL reset Re_out: got %0d want 0", re_out); end
        total++; if (im_out !== 16'sd0) begin bad++; $display("FAIL reset Im_out: got %0d want 0", im_out); end
        total++; if (tw_addr !== 2'd0) begin bad++; $display("FAIL reset tw_addr: got %0d want 0", tw_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev) begin bad++; $display("FAIL idle valid: got %0b want %0b", ov, ev); end
            total++; if (oa !== ea) begin bad++; $display("FAIL idle tw_addr: got %0d want %0d", oa, ea); end
        end
    endtask

    task automatic test_basic();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        int stim[12] = '{100, 200, 300, 400, 10, 10, 10, 10, 0, 0, 0, 0};
`ifdef IFFT_STAGE_SCALE_EN
        int want[8] = '{55, 105, 155, 205, 45, 95, 145, 195};
`else
        int want[8] = '{110, 210, 310, 410, 90, 190, 290, 390};
`endif
        int got_re[$];
        logic got_last[$];
        reset_dut();
        set_lut(16384, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, stim[i], 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev) begin bad++; $display("FAIL basic valid[%0d]: got %0b want %0b", i, ov, ev); end
            total++; if (ol !== el) begin bad++; $display("FAIL basic last[%0d]: got %0b want %0b", i, ol, el); end
            total++; if (oa !== ea) begin bad++; $display("FAIL basic tw_addr[%0d]: got %0d want %0d", i, oa, ea); end
            if (ev) begin
                total++;
                if (ore !== er || oim !== ei) begin
                    bad++; $display("FAIL basic data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ore, oim, er, ei);
                end
            end
            if (ov === 1'b1) begin
                got_re.push_back(ore);
                got_last.push_back(ol);
            end
        end
        total++;
        if (got_re.size() != 8) begin
            bad++; $display("FAIL basic count: got %0d want 8", got_re.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (got_re[i] !== want[i]) begin bad++; $display("FAIL basic seq[%0d]: got %0d want %0d", i, got_re[i], want[i]); end
            end
            total++; if (got_last[7] !== 1'b1) begin bad++; $display("FAIL basic last flag: got %0b want 1", got_last[7]); end
        end
    endtask

    task automatic test_rotation();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        int sre, sim;
        int got_re[$];
        int got_im[$];
`ifdef IFFT_STAGE_SCALE_EN
        int w1_im = -45; int w2_re = 35; int w2_im = -36;
`else
        int w1_im = -90; int w2_re = 70; int w2_im = -71;
`endif
        reset_dut();
        set_lut(0, 16384);
        for (int i = 0; i < 20; i++) begin
            if (i == 12) set_lut(11585, 11585);
            sre = (i < 4 || (i >= 8 && i < 12)) ? 100 : ((i < 8) ? 10 : 0);
            sim = 0;
            step(1'b1, sre, sim, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev) begin bad++; $display("FAIL rot valid[%0d]: got %0b want %0b", i, ov, ev); end
            total++; if (ol !== el) begin bad++; $display("FAIL rot last[%0d]: got %0b want %0b", i, ol, el); end
            if (ev) begin
                total++;
                if (ore !== er || oim !== ei) begin
                    bad++; $display("FAIL rot data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ore, oim, er, ei);
                end
            end
            if (ov === 1'b1) begin
                got_re.push_back(ore);
                got_im.push_back(oim);
            end
        end
        total++;
        if (got_re.size() != 16) begin
            bad++; $display("FAIL rot count: got %0d want 16", got_re.size());
        end else begin
            total++; if (got_re[4] !== 0 || got_im[4] !== w1_im) begin bad++; $display("FAIL rot sin-only: got (%0d,%0d) want (0,%0d)", got_re[4], got_im[4], w1_im); end
            total++; if (got_re[12] !== w2_re || got_im[12] !== w2_im) begin bad++; $display("FAIL rot 45deg: got (%0d,%0d) want (%0d,%0d)", got_re[12], got_im[12], w2_re, w2_im); end
        end
    endtask

    task automatic test_overflow();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        int first_re = 1;
        int first_im = 1;
        bit seen = 1'b0;
`ifdef IFFT_STAGE_SCALE_EN
        int w_re = 32767; int w_im = -32768;
`else
        int w_re = -2; int w_im = 0;
`endif
        reset_dut();
        set_lut(16384, 0);
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1'b1, 32767, -32768, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            else       step(1'b1, 0, 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev) begin bad++; $display("FAIL ovf valid[%0d]: got %0b want %0b", i, ov, ev); end
            if (ev) begin
                total++;
                if (ore !== er || oim !== ei) begin
                    bad++; $display("FAIL ovf data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ore, oim, er, ei);
                end
            end
            if (ov === 1'b1 && !seen) begin
                seen = 1'b1;
                first_re = ore;
                first_im = oim;
            end
        end
        total++; if (first_re !== w_re || first_im !== w_im) begin bad++; $display("FAIL ovf sum: got (%0d,%0d) want (%0d,%0d)", first_re, first_im, w_re, w_im); end
    endtask

    task automatic test_stalls();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        int stim[12] = '{100, 200, 300, 400, 10, 10, 10, 10, 0, 0, 0, 0};
`ifdef IFFT_STAGE_SCALE_EN
        int want[8] = '{55, 105, 155, 205, 45, 95, 145, 195};
`else
        int want[8] = '{110, 210, 310, 410, 90, 190, 290, 390};
`endif
        int got_re[$];
        int n_valid = 0;
        int n_primed_acc = 0;
        reset_dut();
        set_lut(16384, 0);
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step(1'b0, 0, 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
                total++; if (ov !== 1'b0 || ol !== 1'b0) begin bad++; $display("FAIL stall gap[%0d]: got valid=%0b last=%0b want 0", i, ov, ol); end
                total++; if (oa !== ea) begin bad++; $display("FAIL stall tw_addr[%0d]: got %0d want %0d", i, oa, ea); end
            end
            step(1'b1, stim[i], 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            if (i >= D) n_primed_acc++;
            total++; if (ov !== ev || ol !== el) begin bad++; $display("FAIL stall flags[%0d]: got %0b/%0b want %0b/%0b", i, ov, ol, ev, el); end
            if (ov === 1'b1) begin
                n_valid++;
                got_re.push_back(ore);
            end
        end
        total++; if (n_valid !== n_primed_acc) begin bad++; $display("FAIL stall count: got %0d want %0d", n_valid, n_primed_acc); end
        if (got_re.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                total++; if (got_re[i] !== want[i]) begin bad++; $display("FAIL stall seq[%0d]: got %0d want %0d", i, got_re[i], want[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        bit v;
        int re, im;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                for (int k = 0; k < D; k++) begin
                    lut_cos[k] = 16'(int'($urandom_range(0, 32768)) - 16384);
                    lut_sin[k] = 16'(int'($urandom_range(0, 32768)) - 16384);
                end
            end
            v  = ($urandom_range(0, 9) < 7);
            re = int'($urandom_range(0, 65535)) - 32768;
            im = int'($urandom_range(0, 65535)) - 32768;
            step(v, re, im, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev || ol !== el) begin bad++; $display("FAIL rand flags[%0d]: got %0b/%0b want %0b/%0b", i, ov, ol, ev, el); end
            total++; if (oa !== ea) begin bad++; $display("FAIL rand tw_addr[%0d]: got %0d want %0d", i, oa, ea); end
            if (ev) begin
                total++;
                if (ore !== er || oim !== ei) begin
                    bad++; $display("FAIL rand data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ore, oim, er, ei);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ov, ol;
        int ore, oim, oa, er, ei, ea;
        bit ev, el;
        int stim[8] = '{100, 200, 300, 400, 10, 10, 10, 10};
        reset_dut();
        set_lut(16384, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, stim[i], 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev) begin bad++; $display("FAIL midrst pre valid[%0d]: got %0b want %0b", i, ov, ev); end
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid: got %0b want 0", out_valid); end
        total++; if (re_out !== 16'sd0 || im_out !== 16'sd0) begin bad++; $display("FAIL midrst data: got (%0d,%0d) want (0,0)", re_out, im_out); end
        total++; if (tw_addr !== 2'd0) begin bad++; $display("FAIL midrst tw_addr: got %0d want 0", tw_addr); end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, stim[i], 0, ov, ol, ore, oim, oa, ev, el, er, ei, ea);
            total++; if (ov !== ev || ol !== el) begin bad++; $display("FAIL midrst flags[%0d]: got %0b/%0b want %0b/%0b", i, ov, ol, ev, el); end
            if (ev) begin
                total++;
                if (ore !== er || oim !== ei) begin
                    bad++; $display("FAIL midrst data[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ore, oim, er, ei);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_rotation();
        test_overflow();
        test_stalls();
        test_random();
        test_reset_mid();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
